alu_ctrl_8bit: RTL and testbench



---
 rtl/alu_ctrl_8bit.sv | 144 ++++++++++++++
 tb/tb_alu_ctrl_8bit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_8bit.sv
// alu_ctrl_8bit: valid/ready command front end around an 8-bit ALU, with an optional accumulator
//
// Ports:
//   clk, rst                    rising-edge clock, synchronous active-high reset
//   cmd_valid / cmd_ready       command handshake; cmd_ready is high only in IDLE
//   cmd_op, cmd_a, cmd_b,       opcode (opaque to the controller), signed operands,
//   cmd_cin, cmd_use_acc        carry-in, take operand A from the accumulator
//   rsp_valid / rsp_ready       response handshake
//   rsp_x, rsp_cout, rsp_ov,    registered ALU result and flags
//   rsp_zero
//   acc_q                       accumulator value (8'h00 when the accumulator is not built)
//
// Build option: define ALU_CTRL_ACC_EN to include the accumulator register.
//
// ALU opcodes (ALU_cont): 0000 AND, 0001 OR, 0011 XOR, 1100 NOR,
//   0010 ADD  X = A + B + Cin
//   0110 SUB  X = A - B - Cin, Cout = no borrow
//   0111 SLT  X = (A < B) signed
//   others    X = 0
module alu_ctrl_8bit (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic       cmd_cin,
    input  logic       cmd_use_acc,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_x,
    output logic       rsp_cout,
    output logic       rsp_ov,
    output logic       rsp_zero,
    output logic [7:0] acc_q
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0] state;
    logic       settle;
    logic [3:0] op_q;
    logic [7:0] a_q, b_q, alu_a, x;
    logic       cin_q, cout, ov, zero;
    logic [8:0] sum;
    logic       capture;

    assign cmd_ready = state == IDLE;
    assign rsp_valid = state == RESP;
    // EXEC spans two cycles: the first lets the registered operands settle
    // through the ALU, the second captures the result.
    assign capture   = state == EXEC && settle;

`ifdef ALU_CTRL_ACC_EN
    logic [7:0] acc;
    logic       use_acc_q;
    assign alu_a = use_acc_q ? acc : a_q;
    assign acc_q = acc;
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            use_acc_q <= 1'b0;
        end else begin
            if (cmd_valid && cmd_ready)
                use_acc_q <= cmd_use_acc;
            if (capture)
                acc <= x;
        end
    end
`else
    logic use_acc_unused;
    assign use_acc_unused = cmd_use_acc;
    assign alu_a = a_q;
    assign acc_q = 8'h00;
`endif

    always_comb begin
        sum  = '0;
        x    = '0;
        cout = 1'b0;
        ov   = 1'b0;
        case (op_q)
            4'b0000: x = alu_a & b_q;
            4'b0001: x = alu_a | b_q;
            4'b0011: x = alu_a ^ b_q;
            4'b1100: x = ~(alu_a | b_q);
            4'b0010: begin
                sum  = {1'b0, alu_a} + {1'b0, b_q} + {8'b0, cin_q};
                x    = sum[7:0];
                cout = sum[8];
                ov   = (alu_a[7] == b_q[7]) && (x[7] != alu_a[7]);
            end
            4'b0110: begin
                // A - B - Cin as A + ~B + ~Cin; carry out means no borrow
                sum  = {1'b0, alu_a} + {1'b0, ~b_q} + {8'b0, ~cin_q};
                x    = sum[7:0];
                cout = sum[8];
                ov   = (alu_a[7] != b_q[7]) && (x[7] != alu_a[7]);
            end
            4'b0111: x = {7'b0, $signed(alu_a) < $signed(b_q)};
            default: x = '0;
        endcase
        zero = x == 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            settle   <= 1'b0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            rsp_x    <= '0;
            rsp_cout <= 1'b0;
            rsp_ov   <= 1'b0;
            rsp_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    op_q   <= cmd_op;
                    a_q    <= cmd_a;
                    b_q    <= cmd_b;
                    cin_q  <= cmd_cin;
                    settle <= 1'b0;
                    state  <= EXEC;
                end
                EXEC: if (!settle) begin
                    settle <= 1'b1;
                end else begin
                    rsp_x    <= x;
                    rsp_cout <= cout;
                    rsp_ov   <= ov;
                    rsp_zero <= zero;
                    state    <= RESP;
                end
                RESP: if (rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_ctrl_8bit.sv
// tb_alu_ctrl_8bit: table vectors, handshake corner cases and randomized commands against an arithmetic model
module tb_alu_ctrl_8bit;
`ifdef ALU_CTRL_ACC_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0, cmd_ready;
    logic [3:0] cmd_op = '0;
    logic [7:0] cmd_a = '0, cmd_b = '0;
    logic       cmd_cin = 1'b0, cmd_use_acc = 1'b0;
    logic       rsp_valid, rsp_ready = 1'b0;
    logic [7:0] rsp_x, acc_q;
    logic       rsp_cout, rsp_ov, rsp_zero;

    int tests = 0;
    int fails = 0;
    logic [7:0] acc_m = '0;

    alu_ctrl_8bit dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .cmd_cin(cmd_cin), .cmd_use_acc(cmd_use_acc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_x(rsp_x), .rsp_cout(rsp_cout), .rsp_ov(rsp_ov), .rsp_zero(rsp_zero),
        .acc_q(acc_q)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0] op;
        logic [7:0] a, b;
        logic       cin;
        logic [7:0] x;
        logic       c, o, z;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference ALU from plain integer arithmetic; returns {x, cout, ov, zero}
    function automatic logic [10:0] model(input logic [3:0] op, input logic [7:0] a, b, input logic cin);
        int ua = a, ub = b, sa = $signed(a), sb = $signed(b), ci = cin;
        int r = 0, c = 0, o = 0, s = 0;
        case (op)
            4'd0:  r = ua & ub;
            4'd1:  r = ua | ub;
            4'd3:  r = ua ^ ub;
            4'd12: r = ~(ua | ub);
            4'd2: begin
                r = ua + ub + ci;
                c = (r > 255) ? 1 : 0;
                s = sa + sb + ci;
                o = (s > 127 || s < -128) ? 1 : 0;
            end
            4'd6: begin
                r = ua - ub - ci;
                c = (r >= 0) ? 1 : 0;
                s = sa - sb - ci;
                o = (s > 127 || s < -128) ? 1 : 0;
            end
            4'd7:  r = (sa < sb) ? 1 : 0;
            default: r = 0;
        endcase
        r = r & 255;
        return {r[7:0], c[0], o[0], r == 0};
    endfunction

    // One command through both handshakes; bp > 0 holds rsp_ready low for bp cycles
    // after rsp_valid and fires a stray command pulse that must be ignored.
    task automatic run_cmd(input logic [3:0] op, input logic [7:0] a, b, input logic cin, ua,
                           input int bp, output logic [10:0] res);
        int n;
        int bad;
        logic [10:0] snap;
        @(negedge clk);
        n = 0;
        while (!cmd_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_in_idle", int'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_cin = cin; cmd_use_acc = ua;
        rsp_ready = (bp == 0);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 4'($urandom); cmd_a = 8'($urandom); cmd_b = 8'($urandom);
        chk("cmd_ready_low_exec", int'(cmd_ready), 0);
        n = 0;
        while (!rsp_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("accept_to_rsp_valid", n, 2);
        res  = {rsp_x, rsp_cout, rsp_ov, rsp_zero};
        snap = res;
        bad = 0;
        for (int i = 0; i < bp; i++) begin
            if (i > 0) @(negedge clk);
            if (!rsp_valid || cmd_ready || {rsp_x, rsp_cout, rsp_ov, rsp_zero} != snap) bad++;
            if (i == 3) begin
                cmd_valid = 1'b1; cmd_op = 4'd1; cmd_a = 8'h55; cmd_b = 8'hAA;
            end
            if (i == 4) cmd_valid = 1'b0;
        end
        if (bp > 0) chk("backpressure_hold", bad, 0);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("rsp_consumed", int'(rsp_valid), 0);
        chk("cmd_ready_after_rsp", int'(cmd_ready), 1);
        rsp_ready = 1'b0;
    endtask

    task automatic check_cmd(input string nm, input logic [3:0] op, input logic [7:0] a, b,
                             input logic cin, ua, input int bp);
        logic [10:0] res, exp;
        run_cmd(op, a, b, cin, ua, bp, res);
        exp = model(op, (ACC && ua) ? acc_m : a, b, cin);
        chk(nm, int'(res), int'(exp));
        acc_m = ACC ? exp[10:3] : 8'h00;
        chk({nm, "_acc"}, int'(acc_q), int'(acc_m));
    endtask

    initial begin
        vec_t vecs[9];
        logic [10:0] res;
        logic [3:0] opl[8];
        int bad;
        vecs[0] = '{4'b0010, 8'd13,  8'd7,  1'b0, 8'd20,  1'b0, 1'b0, 1'b0};
        vecs[1] = '{4'b0010, 8'd100, 8'd100,1'b0, 8'hC8,  1'b0, 1'b1, 1'b0};
        vecs[2] = '{4'b0110, 8'd5,   8'd5,  1'b0, 8'h00,  1'b1, 1'b0, 1'b1};
        vecs[3] = '{4'b0010, 8'hFF,  8'h01, 1'b0, 8'h00,  1'b1, 1'b0, 1'b1};
        vecs[4] = '{4'b0110, 8'h80,  8'h01, 1'b0, 8'h7F,  1'b1, 1'b1, 1'b0};
        vecs[5] = '{4'b0000, 8'hF0,  8'h3C, 1'b0, 8'h30,  1'b0, 1'b0, 1'b0};
        vecs[6] = '{4'b0111, 8'hFF,  8'h01, 1'b0, 8'h01,  1'b0, 1'b0, 1'b0};
        vecs[7] = '{4'b0010, 8'h7F,  8'h00, 1'b1, 8'h80,  1'b0, 1'b1, 1'b0};
        vecs[8] = '{4'b1100, 8'h0F,  8'hF0, 1'b0, 8'h00,  1'b0, 1'b0, 1'b1};

        // reset held two cycles with a command presented
        cmd_valid = 1'b1; cmd_op = 4'b0010; cmd_a = 8'd1; cmd_b = 8'd1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("reset_cmd_ready", int'(cmd_ready), 1);
            chk("reset_rsp_valid", int'(rsp_valid), 0);
            chk("reset_rsp", int'({rsp_x, rsp_cout, rsp_ov, rsp_zero}), 0);
            chk("reset_acc", int'(acc_q), 0);
        end
        rst = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("no_accept_in_reset", int'(cmd_ready), 1);

        for (int i = 0; i < 9; i++) begin
            run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, 0, res);
            chk($sformatf("vec%0d", i), int'(res), int'({vecs[i].x, vecs[i].c, vecs[i].o, vecs[i].z}));
            acc_m = ACC ? vecs[i].x : 8'h00;
            chk($sformatf("vec%0d_acc", i), int'(acc_q), int'(acc_m));
        end

        // backpressure for 10 cycles, then exactly one handshake
        check_cmd("backpressure_add", 4'b0010, 8'd40, 8'd2, 1'b0, 1'b0, 10);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid || !cmd_ready) bad++;
        end
        chk("single_handshake", bad, 0);

        // accumulator chain
        check_cmd("chain_first", 4'b0010, 8'd3, 8'd4, 1'b0, 1'b0, 0);
        run_cmd(4'b0010, 8'hFF, 8'd10, 1'b0, 1'b1, 0, res);
        chk("chain_second_x", int'(res[10:3]), ACC ? 17 : 9);
        chk("chain_second_acc", int'(acc_q), ACC ? 17 : 0);
        acc_m = acc_q;

        // reset during EXEC drops the command and clears the accumulator
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 4'b0010; cmd_a = 8'd50; cmd_b = 8'd60; cmd_use_acc = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midop_acc", int'(acc_q), 0);
        chk("midop_rsp", int'({rsp_x, rsp_cout, rsp_ov, rsp_zero}), 0);
        chk("midop_cmd_ready", int'(cmd_ready), 1);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid) bad++;
        end
        chk("midop_no_rsp", bad, 0);
        acc_m = 8'h00;
        check_cmd("after_midop", 4'b0010, 8'd9, 8'd8, 1'b1, 1'b1, 0);

        // randomized commands
        opl = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd12, 4'd0};
        for (int i = 0; i < 40; i++) begin
            opl[7] = 4'($urandom);
            check_cmd($sformatf("rand%0d", i), opl[$urandom_range(0, 7)], 8'($urandom), 8'($urandom),
                      1'($urandom), 1'($urandom), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
